// File: rtl/btb_assoc_if.sv
// btb_assoc_if: lookup, update/invalidate and flush-sweep signals of the
// set-associative branch target buffer. Port p of a packed vector sits at
// [32p+:32] (PCs/targets), [2p+:2] (types) or [p] (enables/hits).
// Optional macro BTB_STATS_EN adds the stat_lookups/stat_hits counters.
interface btb_assoc_if #(
  parameter int RD_PORTS = 2
);
  logic [RD_PORTS-1:0]    lu_en;
  logic [RD_PORTS*32-1:0] lu_pc;
  logic [RD_PORTS-1:0]    lu_hit;
  logic [RD_PORTS*32-1:0] lu_target;
  logic [RD_PORTS*2-1:0]  lu_type;
  logic                   upd_en;
  logic [31:0]            upd_pc;
  logic [31:0]            upd_target;
  logic [1:0]             upd_type;
  logic                   inv_en;
  logic [31:0]            inv_pc;
  logic                   flush_req;
  logic                   busy;
`ifdef BTB_STATS_EN
  logic [31:0]            stat_lookups;
  logic [31:0]            stat_hits;

  modport master (
    output lu_en, lu_pc, upd_en, upd_pc, upd_target, upd_type, inv_en, inv_pc, flush_req,
    input  lu_hit, lu_target, lu_type, busy, stat_lookups, stat_hits
  );
  modport slave (
    input  lu_en, lu_pc, upd_en, upd_pc, upd_target, upd_type, inv_en, inv_pc, flush_req,
    output lu_hit, lu_target, lu_type, busy, stat_lookups, stat_hits
  );
`else
  modport master (
    output lu_en, lu_pc, upd_en, upd_pc, upd_target, upd_type, inv_en, inv_pc, flush_req,
    input  lu_hit, lu_target, lu_type, busy
  );
  modport slave (
    input  lu_en, lu_pc, upd_en, upd_pc, upd_target, upd_type, inv_en, inv_pc, flush_req,
    output lu_hit, lu_target, lu_type, busy
  );
`endif
endinterface

// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with RD_PORTS registered
// lookups, tree pseudo-LRU replacement, per-entry invalidation and a
// one-set-per-cycle flush-all sweep. Index = pc[IDX+1:2], tag = pc[31:IDX+2].
// Optional macro BTB_STATS_EN adds lookup/hit counters at the output stage.
module btb_assoc #(
  parameter int SETS     = 32,
  parameter int WAYS     = 2,
  parameter int RD_PORTS = 2
) (
  input logic          clk,
  input logic          rst_n,
  btb_assoc_if.slave   bus
);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = 30 - IDX;
  localparam int WB    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PW    = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e           state, state_next;
  logic [IDX-1:0]   cnt, cnt_next;

  logic [WAYS-1:0]  valid    [SETS];
  logic [PW-1:0]    plru     [SETS];
  logic [PW-1:0]    plru_next[SETS];
  logic [TAG_W-1:0] tag_mem  [SETS][WAYS];
  logic [31:0]      tgt_mem  [SETS][WAYS];
  logic [1:0]       type_mem [SETS][WAYS];

  function automatic logic [IDX-1:0] pc_idx(input logic [31:0] pc);
    return pc[IDX+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
    return pc[31:IDX+2];
  endfunction

  // Tree bits point at the victim: bit0 picks the half (0 = low), bit 1+half
  // picks the way inside that half. A touch points the path away from the way.
  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] cur, input logic [1:0] way);
    logic [2:0] b;
    b = 3'(cur);
    if (WAYS == 2) begin
      b[0] = ~way[0];
    end else if (WAYS == 4) begin
      b[0] = ~way[1];
      if (way[1]) b[2] = ~way[0];
      else        b[1] = ~way[0];
    end
    return b[PW-1:0];
  endfunction

  function automatic logic [1:0] plru_victim(input logic [PW-1:0] cur);
    logic [2:0] b;
    b = 3'(cur);
    if (WAYS == 2) return {1'b0, b[0]};
    if (WAYS == 4) return b[0] ? {1'b1, b[2]} : {1'b0, b[1]};
    return 2'd0;
  endfunction

  // Requests are only honoured in IDLE and not while a sweep is being launched.
  logic accept;
  assign accept = (state == IDLE) && !bus.flush_req;

  // ---------------------------------------------------------------- lookup
  logic [RD_PORTS-1:0] hit_c;
  logic [WB-1:0]       way_c  [RD_PORTS];
  logic [31:0]         tgt_c  [RD_PORTS];
  logic [1:0]          type_c [RD_PORTS];

  // Tag compare of every port against the pre-write contents of its set.
  // NOTE: every variable gets a default before any condition, so no path can
  // leave one unassigned and no latch is inferred.
  always_comb begin
    for (int p = 0; p < RD_PORTS; p++) begin
      hit_c[p]  = 1'b0;
      way_c[p]  = '0;
      tgt_c[p]  = '0;
      type_c[p] = '0;
      for (int w = 0; w < WAYS; w++) begin
        if (accept && bus.lu_en[p] &&
            valid[pc_idx(bus.lu_pc[32*p +: 32])][w] &&
            tag_mem[pc_idx(bus.lu_pc[32*p +: 32])][w] == pc_tag(bus.lu_pc[32*p +: 32])) begin
          hit_c[p]  = 1'b1;
          way_c[p]  = WB'(w);
          tgt_c[p]  = tgt_mem[pc_idx(bus.lu_pc[32*p +: 32])][w];
          type_c[p] = type_mem[pc_idx(bus.lu_pc[32*p +: 32])][w];
        end
      end
    end
  end

  logic [RD_PORTS-1:0]    hit_q;
  logic [RD_PORTS*32-1:0] target_q;
  logic [RD_PORTS*2-1:0]  type_q;
  logic [WB-1:0]          hit_way_q [RD_PORTS];
  logic [IDX-1:0]         hit_idx_q [RD_PORTS];

  // Output stage; the hit way/set is kept so PLRU is touched in the output cycle.
  // NOTE: all state uses non-blocking assignments, so every flop samples the
  // pre-edge array contents; this is what gives lookups read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q    <= '0;
      target_q <= '0;
      type_q   <= '0;
      for (int p = 0; p < RD_PORTS; p++) begin
        hit_way_q[p] <= '0;
        hit_idx_q[p] <= '0;
      end
    end else begin
      hit_q <= hit_c;
      for (int p = 0; p < RD_PORTS; p++) begin
        target_q[32*p +: 32] <= tgt_c[p];
        type_q[2*p +: 2]     <= type_c[p];
        hit_way_q[p]         <= way_c[p];
        hit_idx_q[p]         <= pc_idx(bus.lu_pc[32*p +: 32]);
      end
    end
  end

  assign bus.lu_hit    = hit_q;
  assign bus.lu_target = target_q;
  assign bus.lu_type   = type_q;

  // ------------------------------------------------------ update/invalidate
  logic [IDX-1:0]   upd_idx, inv_idx;
  logic [TAG_W-1:0] upd_tag, inv_tag;
  logic             upd_match, inv_match, has_free, upd_go, inv_go;
  logic [WB-1:0]    upd_hit_way, inv_way, free_way, upd_way;

  assign upd_idx = pc_idx(bus.upd_pc);
  assign upd_tag = pc_tag(bus.upd_pc);
  assign inv_idx = pc_idx(bus.inv_pc);
  assign inv_tag = pc_tag(bus.inv_pc);

  // An invalidate of the very entry being updated wins: the update is dropped.
  assign upd_go = bus.upd_en && accept &&
                  !(bus.inv_en && upd_idx == inv_idx && upd_tag == inv_tag);
  assign inv_go = bus.inv_en && accept;

  // Way selection for update (hit, else lowest free, else PLRU) and invalidate.
  always_comb begin
    upd_match   = 1'b0;
    upd_hit_way = '0;
    inv_match   = 1'b0;
    inv_way     = '0;
    has_free    = 1'b0;
    free_way    = '0;
    upd_way     = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[upd_idx][w] && tag_mem[upd_idx][w] == upd_tag) begin
        upd_match   = 1'b1;
        upd_hit_way = WB'(w);
      end
      if (valid[inv_idx][w] && tag_mem[inv_idx][w] == inv_tag) begin
        inv_match = 1'b1;
        inv_way   = WB'(w);
      end
      if (!valid[upd_idx][w]) begin
        has_free = 1'b1;
        free_way = WB'(w);
      end
    end
    if (upd_match)     upd_way = upd_hit_way;
    else if (has_free) upd_way = free_way;
    else               upd_way = WB'(plru_victim(plru[upd_idx]));
  end

  // Valid bits: sweep clears one set per cycle; otherwise invalidate, then update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) valid[s] <= '0;
    end else if (state == FLUSH) begin
      valid[cnt] <= '0;
    end else begin
      if (inv_go && inv_match) valid[inv_idx][inv_way] <= 1'b0;
      if (upd_go)              valid[upd_idx][upd_way] <= 1'b1;
    end
  end

  // Payload write on update.
  // NOTE: tag/target/type storage has no reset; the valid bits gate every read.
  always_ff @(posedge clk) begin
    if (upd_go) begin
      tag_mem[upd_idx][upd_way]  <= upd_tag;
      tgt_mem[upd_idx][upd_way]  <= bus.upd_target;
      type_mem[upd_idx][upd_way] <= bus.upd_type;
    end
  end

  // --------------------------------------------------------------- PLRU
  logic plru_dup;

  // One touch per set per cycle: the update wins, then the lowest hitting port.
  always_comb begin
    plru_next = plru;
    plru_dup  = 1'b0;
    for (int p = 0; p < RD_PORTS; p++) begin
      plru_dup = upd_go && (upd_idx == hit_idx_q[p]);
      for (int q = 0; q < p; q++) begin
        if (hit_q[q] && hit_idx_q[q] == hit_idx_q[p]) plru_dup = 1'b1;
      end
      if (hit_q[p] && !plru_dup)
        plru_next[hit_idx_q[p]] = plru_touch(plru[hit_idx_q[p]], 2'(hit_way_q[p]));
    end
    if (upd_go) plru_next[upd_idx] = plru_touch(plru[upd_idx], 2'(upd_way));
  end

  // PLRU state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) plru[s] <= '0;
    end else begin
      plru <= plru_next;
    end
  end

  // ---------------------------------------------------------------- FSM
  // Sweep sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // IDLE -> FLUSH on flush_req; FLUSH visits sets 0..SETS-1, one per cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.flush_req) begin
          state_next = FLUSH;
          cnt_next   = '0;
        end
      end
      FLUSH: begin
        cnt_next = cnt + 1'b1;
        if (cnt == IDX'(SETS - 1)) state_next = IDLE;
      end
    endcase
  end

  assign bus.busy = (state == FLUSH);

`ifdef BTB_STATS_EN
  logic [RD_PORTS-1:0] en_q;
  logic [31:0]         stat_lookups_q, stat_hits_q;

  // Counters advance at the output stage and hold while the sweep runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q           <= '0;
      stat_lookups_q <= '0;
      stat_hits_q    <= '0;
    end else begin
      en_q <= bus.lu_en;
      if (state != FLUSH) begin
        stat_lookups_q <= stat_lookups_q + 32'($countones(en_q));
        stat_hits_q    <= stat_hits_q + 32'($countones(hit_q));
      end
    end
  end

  assign bus.stat_lookups = stat_lookups_q;
  assign bus.stat_hits    = stat_hits_q;
`endif

endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
Parametrised set-associative branch target buffer, successor to the direct-mapped BTB in the scalar front end. Serves RD_PORTS fetch lookups per cycle with registered (1-cycle) outputs. Uses per-set tree pseudo-LRU replacement and per-entry invalidation. Adds a multi-cycle flush-all sweep used on fence.i and context switch.

Parameters:
SETS, 32, number of sets; power of 2, >=2; IDX=$clog2(SETS)
WAYS, 2, associativity; must be 1, 2 or 4
RD_PORTS, 2, independent lookup ports
TAG_W, 30-IDX, tag width = pc[31:IDX+2]

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
lu_en  in  RD_PORTS  lookup request per port
lu_pc  in  RD_PORTS*32  lookup PC, port p at [32p+:32]
lu_hit  out  RD_PORTS  registered hit
lu_target  out  RD_PORTS*32  registered predicted target
lu_type  out  RD_PORTS*2  registered branch type
upd_en  in  1  write/refresh entry
upd_pc  in  32  branch PC
upd_target  in  32  resolved target
upd_type  in  2  branch type
inv_en  in  1  invalidate entry matching inv_pc
inv_pc  in  32  PC to invalidate
flush_req  in  1  start flush-all sweep (pulse)
busy  out  1  high while sweep runs

Behaviour:
- Index = pc[IDX+1:2], tag = pc[31:IDX+2]; pc[1:0] ignored. Clock is clk, reset is rst_n: asynchronous, active-low.
- Reset: all valid bits 0, all PLRU state 0, FSM=IDLE, busy=0, lu_hit=0, lu_target=0, lu_type=0. Tag/target storage is not reset.
- Lookup: the request at cycle N produces outputs at N+1.
  - lu_hit[p] = lu_en[p] & some valid way with a tag match.
  - On hit, target/type come from the matching way. On miss, lu_target=0 and lu_type=0.
  - Tags never duplicate within a set, so at most one way matches.
- Read-before-write: a lookup in the same cycle as an update/invalidate of the same set sees the pre-write contents.
- Update (applied at clock edge):
  - Tag hit: overwrite target/type in the matching way.
  - Tag miss: allocate the lowest-index invalid way, else the PLRU victim. Set valid.
- PLRU: tree with WAYS-1 bits per set (WAYS=1: none).
  - Touched on an update write, and on each lookup hit (at the output cycle).
  - Several touches to one set in one cycle: update wins, then the lowest-index port.
- Invalidate: clears the valid bit of the matching way only; no-op on miss. Invalidate and update to the same index+tag in one cycle: invalidate wins and the entry ends invalid. Different ways or sets: both apply.
- FSM IDLE/FLUSH:
  - IDLE, flush_req=1: go to FLUSH, cnt=0, busy=1 from the next cycle.
  - FLUSH: clear all ways of set cnt each cycle, cnt++. When cnt==SETS-1 the last set is cleared, return to IDLE, busy=0 the next cycle. Sweep takes exactly SETS cycles.
  - While busy: lu_hit forced 0, upd_en and inv_en dropped, flush_req ignored.
  - flush_req with upd_en in the same IDLE cycle: flush wins and the update is dropped.
- Reset mid-flush: returns to IDLE with all state cleared immediately.

Optional Feature:
BTB_STATS_EN: adds outputs stat_lookups[31:0] and stat_hits[31:0], reset 0.
- Each increments once per cycle, by the popcount of lu_en and of lu_hit respectively.
- Counts are taken at the output stage, wrap modulo 2^32, and hold during busy.
- Without the macro the ports and counters do not exist.

Test Plan:
- Reset, then lu_en=1, lu_pc=0x100 -> lu_hit=0, lu_target=0 next cycle.
- upd 0x100->0x2000 type 1, lookup 0x100 next cycle -> hit=1, target=0x2000, type=1, one cycle after lookup; port 1 same PC same cycle -> identical result.
- SETS=32, WAYS=2: upd 0x100, 0x180, 0x200 (all set 0), touching 0x100 via lookup before the third -> 0x180 evicted; 0x100 and 0x200 hit, 0x180 misses.
- Same-cycle inv_en and upd_en on 0x100 after it is installed -> next lookup of 0x100 misses; lookup in the same cycle as a 0x100 update returns old data.
- Fill 8 entries, pulse flush_req -> busy high exactly 32 cycles, all lookups miss during and after; upd_en during busy has no effect.
- Assert rst_n low at flush cycle 10 -> busy=0, all outputs 0 immediately; after release, new updates install normally.
